// File: rtl/scsi_port_arbiter.sv
// ----------------------------------------------------------------------------
// scsi_port_arbiter
//
// Owns the 8-bit SCSI chip port. CPU register cycles (CCPUREQ) and DMA byte
// transfers (CDREQ_) compete for the port. When both are ready at once, the
// grant alternates between them.
// The block sequences chip-select, strobe and DSACK timing. It moves 32-bit
// FIFO words as four byte transfers and keeps the byte-offset (lane) counter.
//
// Optional feature macro: SCSI_DSACK_TIMEOUT_EN
//   defined   -> a WAIT watchdog aborts a cycle after DSACK_TIMEOUT cycles
//                and sets the sticky BUS_ERR flag (cleared by ERR_CLR)
//   undefined -> WAIT waits forever, BUS_ERR is tied 0, ERR_CLR is unused
//
// Ports
//   CLK, RST_            clock, asynchronous active-low reset
//   CCPUREQ, RW          CPU register request and direction (1 = read chip)
//   CPU_ACK              one-cycle pulse when a CPU cycle completes
//   DMAENA, DMADIR       DMA enable and direction (1 = SCSI->FIFO)
//   CDREQ_, CDSACK_      chip DMA request and cycle acknowledge (active low)
//   FIFOEMPTY, FIFOFULL  FIFO status
//   FLUSH                push a partially assembled SCSI->FIFO word
//   RDFIFO, RIFIFO       FIFO pop / push pulses
//   BO, BOEQ3            current DMA byte lane, and BO==3
//   LBYTE                latch chip read data this cycle
//   SCSI_CS_/RE_/WE_     chip select and strobes (active low)
//   DACK_                DMA acknowledge to chip (active low)
//   BUS_ERR, ERR_CLR     sticky DSACK timeout flag and its clear
// ----------------------------------------------------------------------------
module scsi_port_arbiter #(
    parameter int STROBE_CYCLES = 2,
    parameter int DSACK_TIMEOUT = 64
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       CCPUREQ,
    input  logic       RW,
    output logic       CPU_ACK,
    input  logic       DMAENA,
    input  logic       DMADIR,
    input  logic       CDREQ_,
    input  logic       CDSACK_,
    input  logic       FIFOEMPTY,
    input  logic       FIFOFULL,
    input  logic       FLUSH,
    output logic       RDFIFO,
    output logic       RIFIFO,
    output logic [1:0] BO,
    output logic       BOEQ3,
    output logic       LBYTE,
    output logic       SCSI_CS_,
    output logic       SCSI_RE_,
    output logic       SCSI_WE_,
    output logic       DACK_,
    output logic       BUS_ERR,
    input  logic       ERR_CLR
);

    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SETUP, STROBE, WAIT, STORE, RECOVER
    } state_t;

    state_t        state;
    logic [SW-1:0] strobe_cnt;
    logic          cyc_dma;
    logic          cyc_read;
    logic          last_cpu;
    logic          aborted;
    logic          cpu_rdy;
    logic          dma_rdy;
    logic          grant_cpu;
    logic          grant_dma;

`ifdef SCSI_DSACK_TIMEOUT_EN
    localparam int TW = $clog2(DSACK_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(DSACK_TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
`else
    // Without the watchdog a cycle can never abort and no error is raised.
    localparam int unused_timeout = DSACK_TIMEOUT;
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign aborted        = 1'b0;
    assign BUS_ERR        = 1'b0;
`endif

    // A DMA request is only useful if there is somewhere to put or get the
    // byte. FIFO->SCSI with BO != 0 still has bytes left in the fetched word.
    always_comb begin
        cpu_rdy   = CCPUREQ;
        dma_rdy   = DMAENA & ~CDREQ_ & ~BUS_ERR &
                    (DMADIR ? ~FIFOFULL : ((BO != 2'd0) | ~FIFOEMPTY));
        // On a tie, whoever did not win last time gets the port.
        grant_cpu = cpu_rdy & (~dma_rdy | ~last_cpu);
        grant_dma = dma_rdy & (~cpu_rdy | last_cpu);
    end

    // Port sequencer. Each output is written on the edge that enters the
    // state it belongs to, so the outputs line up with the state register.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state      <= IDLE;
            strobe_cnt <= '0;
            cyc_dma    <= 1'b0;
            cyc_read   <= 1'b0;
            last_cpu   <= 1'b0;
            CPU_ACK    <= 1'b0;
            RDFIFO     <= 1'b0;
            RIFIFO     <= 1'b0;
            BO         <= 2'd0;
            BOEQ3      <= 1'b0;
            LBYTE      <= 1'b0;
            SCSI_CS_   <= 1'b1;
            SCSI_RE_   <= 1'b1;
            SCSI_WE_   <= 1'b1;
            DACK_      <= 1'b1;
`ifdef SCSI_DSACK_TIMEOUT_EN
            wait_cnt   <= '0;
            aborted    <= 1'b0;
            BUS_ERR    <= 1'b0;
`endif
        end else begin
            CPU_ACK <= 1'b0;
            RDFIFO  <= 1'b0;
            RIFIFO  <= 1'b0;
            LBYTE   <= 1'b0;
`ifdef SCSI_DSACK_TIMEOUT_EN
            if (ERR_CLR) begin
                BUS_ERR <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (grant_dma) begin
                        last_cpu <= 1'b0;
                        cyc_dma  <= 1'b1;
                        cyc_read <= DMADIR;
                        // A new outbound word is needed only at lane 0.
                        if (!DMADIR && BO == 2'd0) begin
                            state  <= FETCH;
                            RDFIFO <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            SCSI_CS_ <= 1'b0;
                            DACK_    <= 1'b0;
                        end
                    end else if (grant_cpu) begin
                        last_cpu <= 1'b1;
                        cyc_dma  <= 1'b0;
                        cyc_read <= RW;
                        state    <= SETUP;
                        SCSI_CS_ <= 1'b0;
                    end else if (FLUSH && DMADIR && BO != 2'd0) begin
                        RIFIFO <= 1'b1;
                        BO     <= 2'd0;
                        BOEQ3  <= 1'b0;
                    end
                end
                FETCH: begin
                    state    <= SETUP;
                    SCSI_CS_ <= 1'b0;
                    DACK_    <= 1'b0;
                end
                SETUP: begin
                    state      <= STROBE;
                    strobe_cnt <= '0;
                    if (cyc_read) begin
                        SCSI_RE_ <= 1'b0;
                    end else begin
                        SCSI_WE_ <= 1'b0;
                    end
                end
                STROBE: begin
                    if (strobe_cnt == STROBE_LAST) begin
                        state <= WAIT;
`ifdef SCSI_DSACK_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        strobe_cnt <= strobe_cnt + SW'(1);
                    end
                end
                WAIT: begin
                    if (!CDSACK_) begin
                        state    <= RECOVER;
                        SCSI_CS_ <= 1'b1;
                        SCSI_RE_ <= 1'b1;
                        SCSI_WE_ <= 1'b1;
                        DACK_    <= 1'b1;
                        LBYTE    <= cyc_read;
                        CPU_ACK  <= ~cyc_dma;
`ifdef SCSI_DSACK_TIMEOUT_EN
                        aborted  <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Chip never answered: end the cycle without data.
                        state    <= RECOVER;
                        SCSI_CS_ <= 1'b1;
                        SCSI_RE_ <= 1'b1;
                        SCSI_WE_ <= 1'b1;
                        DACK_    <= 1'b1;
                        CPU_ACK  <= ~cyc_dma;
                        aborted  <= 1'b1;
                        if (!ERR_CLR) begin
                            BUS_ERR <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
`endif
                    end
                end
                RECOVER: begin
                    // Lane advances only for a DMA byte that really moved.
                    if (cyc_dma && !aborted) begin
                        BO    <= BO + 2'd1;
                        BOEQ3 <= (BO == 2'd2);
                        if (cyc_read && BO == 2'd3) begin
                            state  <= STORE;
                            RIFIFO <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                STORE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
